pipe_reg_chain: RTL and testbench
=================================

// Module: pipe_reg_chain
// PURPOSE
//  Parametrised pipeline register: DEPTH stages of WIDTH-bit load registers, each with a valid bit.
//  Uses a valid/ready handshake, per-stage stall propagation, bubble collapsing and a synchronous flush.
//  Sits between datapath stages, for example IF/ID or ID/EX boundaries, and replaces the fixed 16/32-bit load registers.
//  It adds flow control and occupancy tracking.
// PARAMETERS
//  WIDTH      16          payload width in bits (>=1)
//  DEPTH      2           number of register stages (>=1; DEPTH<1 -> elaboration $error)
//  RESET_VAL  '0 (WIDTH)  value loaded into every stage data register on rst
// PORTS
//  clk        in   1                 rising-edge clock
//  rst        in   1                 synchronous, active-high reset
//  flush      in   1                 drop all in-flight entries (synchronous)
//  in_valid   in   1                 upstream presents in_data
//  in_ready   out  1                 chain accepts in_data this cycle
//  in_data    in   WIDTH             upstream payload
//  out_valid  out  1                 last stage holds a valid entry
//  out_ready  in   1                 downstream accepts out_data this cycle
//  out_data   out  WIDTH             payload of last stage
//  count      out  $clog2(DEPTH+1)   number of valid stages
// BEHAVIOUR
//  Reset and clocking
//  - One clock, clk. Reset rst is synchronous and active-high.
//  - rst has priority over all other inputs.
//  - On rst, every v[i] is 0 and every d[i] is RESET_VAL.
//  - Next cycle: out_valid=0, out_data=RESET_VAL, count=0, in_ready=1 (if flush=0).
//  Stage state and handshake
//  - Stage i (0..DEPTH-1) holds v[i] and d[i]. Define v[-1]=in_valid, d[-1]=in_data, rdy[DEPTH]=out_ready.
//  - go[i]   = v[i] & rdy[i+1]      (stage i hands off this cycle)
//  - rdy[i]  = ~v[i] | go[i]        (stage i can take a new entry)
//  - take[i] = v[i-1] & rdy[i]
//  - Next state: v[i] <= take[i] | (v[i] & ~go[i]). d[i] <= take[i] ? d[i-1] : d[i].
//  - d[i] is held whenever take[i]=0, including while the stage is empty.
//  - in_ready = rdy[0] & ~flush. Transfer in = in_valid & in_ready.
//  - out_valid = v[DEPTH-1], out_data = d[DEPTH-1]. Transfer out = out_valid & out_ready.
//  - rdy is a combinational chain from out_ready to in_ready; no registered skid. This is accepted.
//  - Handshake rule: an entry is never duplicated or lost except by flush or rst.
//  - Handshake rule: out_valid/out_data stay stable while out_valid & ~out_ready.
//  Latency and throughput
//  - Latency: an entry accepted at edge N appears at out_data after edge N+DEPTH-1 (min DEPTH cycles), provided out_ready=1.
//  - Throughput: 1 entry/cycle with continuous out_ready=1.
//  - Bubbles collapse: an empty stage accepts from its predecessor even when downstream is stalled.
//  count
//  - Registered. count <= count + in_xfer - out_xfer. On flush, count <= 0.
//  - count == sum of v[i] at all times; range 0..DEPTH.
//  Boundary conditions
//  - Full (count==DEPTH) and out_ready=0: in_ready=0 and all stages hold.
//  - Full and out_ready=1: accept and emit in the same cycle; count unchanged.
//  - Empty: out_valid=0. in_data takes at least DEPTH cycles to reach the output (no bypass).
//  - flush=1: in_ready=0 that cycle, and in_valid is ignored.
//  - flush=1 with out_valid & out_ready: that out transfer is completed (consumed).
//  - After a flush edge: all v[i]=0 and d[i] keep their old values.
//  - flush & rst together: rst behaviour.
//  - rst asserted mid-transfer: all entries are discarded and no partial state is kept.
// STRUCTURE
//  - Shared package pipe_pkg: typedef struct packed {logic v; logic [W-1:0] d;} is not used.
//  - pipe_pkg holds only the localparam function cnt_w(depth)=$clog2(depth+1).
//  - Sub-module pipe_reg_stage (WIDTH, RESET_VAL): one stage holding v/d.
//    Inputs: prev_v, prev_d, next_rdy, flush. Outputs: v, d, rdy.
//  - The top level instantiates DEPTH copies with a generate loop, plus the count register.
// TESTING  (WIDTH=16, DEPTH=3 unless noted)
//  1. rst=1 one cycle, then idle -> out_valid=0, out_data=16'h0000, count=0, in_ready=1.
//  2. out_ready=1; push 16'hA001..A005 on consecutive cycles -> A001 appears 3 cycles after its accept.
//     One output per cycle follows, in order; count peaks at 3.
//  3. out_ready=0; push A001,A002,A003 -> count=3, in_ready=0.
//     Push A004 is held off. Raise out_ready -> A001 out the same cycle A004 is accepted; count stays 3.
//  4. Bubbles: push B001, idle 1 cycle, push B002 with out_ready=0 -> both settle in stages 2,1.
//     Then push B003 -> count=3 (collapse verified).
//  5. Fill with C001..C003, then flush=1 with out_ready=1 and in_valid=1 (C004).
//     -> C001 consumed; next cycle count=0, out_valid=0, C004 not accepted.
//  6. DEPTH=1, RESET_VAL=16'hFFFF: rst -> out_data=FFFF.
//     Stream D001,D002 at out_ready=1 -> 1-cycle latency, full rate. Then rst mid-stream -> count=0 next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared helpers for the pipeline register chain.
package pipe_pkg;

  // Width of an occupancy counter that must hold 0..depth.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One pipeline stage: valid bit plus payload register with ready/valid handoff.
module pipe_reg_stage #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             prev_v,
  input  logic [WIDTH-1:0] prev_d,
  input  logic             next_rdy,
  output logic             v,
  output logic [WIDTH-1:0] d,
  output logic             rdy
);

  logic go;
  logic take;

  assign go   = v & next_rdy;
  assign rdy  = ~v | go;
  assign take = prev_v & rdy;

  // Payload only moves on a real take; a flushed or empty stage keeps its old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      d <= RESET_VAL;
    end else begin
      if (flush) v <= 1'b0;
      else       v <= take | (v & ~go);
      if (take & ~flush) d <= prev_d;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready pipeline register with bubble collapsing, flush and occupancy count.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int unsigned CW = cnt_w(DEPTH);

  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_reg_chain: DEPTH must be at least 1");
  end

  logic             v   [DEPTH];
  logic [WIDTH-1:0] d   [DEPTH];
  logic             rdy [DEPTH+1];
  logic             in_xfer;
  logic             out_xfer;

  assign rdy[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             pv;
    logic [WIDTH-1:0] pd;

    if (i == 0) begin : g_head
      assign pv = in_valid;
      assign pd = in_data;
    end else begin : g_body
      assign pv = v[i-1];
      assign pd = d[i-1];
    end

    pipe_reg_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .prev_v   (pv),
      .prev_d   (pd),
      .next_rdy (rdy[i+1]),
      .v        (v[i]),
      .d        (d[i]),
      .rdy      (rdy[i])
    );
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Occupancy tracks accepted minus emitted entries; flush empties the chain.
  always_ff @(posedge clk) begin
    if (rst)        count <= '0;
    else if (flush) count <= '0;
    else            count <= count + CW'(in_xfer) - CW'(out_xfer);
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain: DEPTH=3 main instance plus a DEPTH=1 instance.
module tb_pipe_reg_chain;

  localparam int unsigned W = 16;
  localparam int unsigned D = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  logic         rst1, flush1, in_valid1, out_ready1;
  logic [W-1:0] in_data1;
  logic         in_ready1, out_valid1;
  logic [W-1:0] out_data1;
  logic [0:0]   count1;

  pipe_reg_chain #(.WIDTH(W), .DEPTH(D), .RESET_VAL(16'h0000)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  pipe_reg_chain #(.WIDTH(W), .DEPTH(1), .RESET_VAL(16'hFFFF)) dut1 (
    .clk(clk), .rst(rst1), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .count(count1)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [W-1:0] sb[$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data  = '0;
  int           peak       = 0;
  int           acc_edge   = -1;
  int           lat_edge   = -1;
  int           lat_edge2  = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: an in-order FIFO of accepted payloads, consulted every cycle.
  always @(negedge clk) begin
    logic exp_rdy;
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      exp_rdy = ~flush & ((sb.size() < D) | out_ready);
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("count", 32'(count), 32'(sb.size()));
      if (sb.size() == 0) check("out_valid_empty", 32'(out_valid), 32'd0);
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (int'(count) > peak) peak = int'(count);
      if (out_valid && out_data == 16'hA001 && lat_edge < 0) lat_edge = cyc;
      if (out_valid && out_data == 16'hA005 && lat_edge2 < 0) lat_edge2 = cyc;
      if (out_valid && out_ready && sb.size() != 0)
        check("out_data", 32'(out_data), 32'(sb.pop_front()));
      if (flush) sb.delete();
      else if (in_valid && exp_rdy) begin
        if (in_data == 16'hA001 && acc_edge < 0) acc_edge = cyc + 1;
        sb.push_back(in_data);
      end
      prev_stall = out_valid & ~out_ready & ~flush;
      prev_data  = out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] val);
    in_valid = 1'b1;
    in_data  = val;
    step();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    rst1 = 1'b1; flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; in_data1 = '0;
    step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h0000);
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    step();

    // Streaming at full rate
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) push(16'(16'hA000 + k));
    in_valid = 1'b0;
    repeat (5) step();
    check("latency", 32'(lat_edge - acc_edge), 32'(D - 1));
    check("rate", 32'(lat_edge2 - lat_edge), 32'd4);
    check("count_peak", 32'(peak), 32'd3);
    check("drained", 32'(count), 32'd0);

    // Full with downstream stalled, then simultaneous accept and emit
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) push(16'(16'hA000 + k));
    in_valid = 1'b1; in_data = 16'hA004;
    @(negedge clk);
    check("full_count", 32'(count), 32'd3);
    check("full_in_ready", 32'(in_ready), 32'd0);
    step(); step();
    out_ready = 1'b1;
    @(negedge clk);
    check("full_emit_data", 32'(out_data), 32'hA001);
    check("full_accept", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("full_count_kept", 32'(count), 32'd3);
    repeat (4) step();

    // Bubble collapse while stalled
    out_ready = 1'b0;
    push(16'hB001);
    in_valid = 1'b0; step();
    push(16'hB002);
    in_valid = 1'b0; step();
    @(negedge clk);
    check("bubble_count", 32'(count), 32'd2);
    check("bubble_head", 32'(out_data), 32'hB001);
    push(16'hB003);
    in_valid = 1'b0;
    @(negedge clk);
    check("collapse_count", 32'(count), 32'd3);
    out_ready = 1'b1;
    repeat (4) step();

    // Flush with a concurrent output transfer and a refused input
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) push(16'(16'hC000 + k));
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 16'hC004;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    check("flush_out_data", 32'(out_data), 32'hC001);
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_hold_d", 32'(out_data), 32'hC001);
    repeat (3) step();

    // Reset together with flush while entries are in flight
    out_ready = 1'b0;
    push(16'hE001);
    push(16'hE002);
    rst = 1'b1; flush = 1'b1; in_data = 16'hE003;
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_count", 32'(count), 32'd0);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_data", 32'(out_data), 32'h0000);
    step();

    // DEPTH=1 instance with a non-zero reset value
    rst1 = 1'b0;
    @(negedge clk);
    check("d1_rst_data", 32'(out_data1), 32'hFFFF);
    check("d1_rst_count", 32'(count1), 32'd0);
    check("d1_rst_valid", 32'(out_valid1), 32'd0);
    out_ready1 = 1'b1; in_valid1 = 1'b1; in_data1 = 16'hD001;
    step();
    in_data1 = 16'hD002;
    @(negedge clk);
    check("d1_lat_valid", 32'(out_valid1), 32'd1);
    check("d1_lat_data", 32'(out_data1), 32'hD001);
    check("d1_full_ready", 32'(in_ready1), 32'd1);
    step();
    in_data1 = 16'hD003;
    @(negedge clk);
    check("d1_rate_data", 32'(out_data1), 32'hD002);
    check("d1_count", 32'(count1), 32'd1);
    rst1 = 1'b1;
    step();
    rst1 = 1'b0; in_valid1 = 1'b0;
    @(negedge clk);
    check("d1_rst_mid_count", 32'(count1), 32'd0);
    check("d1_rst_mid_data", 32'(out_data1), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
